rsa_mm_dma: RTL and testbench
=============================

Name: rsa_mm_dma

Overview:
- Avalon-MM master front-end for the RSA accelerator.
- On a start pulse it performs these steps:
  - Reads key words d and n from host memory.
  - Streams NUM_BLOCKS ciphertext words to the modular-exponentiation core.
  - Writes each plaintext result back to memory.
- Sits between the Avalon-MM m0 port and the RSA core. The s0 flag register drives start and samples status.
- Only one memory transaction is outstanding at any time.

Parameters:
- DATA_W, 256, memory and core word width
- ADDR_W, 32, Avalon byte-address width
- NUM_BLOCKS, 38, ciphertext blocks per run
- KEY_BASE, 0, byte address of d; n is at KEY_BASE+32
- C_BASE, 64, byte address of ciphertext word 0; word k is at C_BASE+32k
- M_BASE, 64, byte address of result word 0; word k is at M_BASE+32k

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse from the flag register
- status  out  8  0xFF while busy, 0x00 otherwise
- avm_waitrequest  in  1  Avalon slave stall
- avm_address  out  ADDR_W  byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  result word
- avm_readdata  in  DATA_W  returned word
- avm_readdatavalid  in  1  readdata qualifier
- core_d  out  DATA_W  registered exponent
- core_n  out  DATA_W  registered modulus
- core_c  out  DATA_W  ciphertext to core
- core_valid  out  1  core_c is valid
- core_ready  in  1  core accepts core_c
- core_m  in  DATA_W  core result
- core_m_valid  in  1  result valid
- core_m_ready  out  1  result accepted

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0; status=0x00; FSM goes to IDLE; block counter k=0.
  - Reset applied mid-transaction aborts immediately. No completion of an in-flight Avalon access is required.
- FSM states: IDLE, RD_D, WT_D, RD_N, WT_N, RD_C, WT_C, SEND, COMP, WR_M, DONE.
- IDLE:
  - start=1 → RD_D.
  - status becomes 0xFF on the cycle after start.
- Read request states (RD_D, RD_N, RD_C):
  - avm_read=1 with the address held stable.
  - The request is accepted on the first cycle with avm_waitrequest=0. On that cycle go to the matching WT_x and drop avm_read.
- Wait states (WT_x):
  - Wait for avm_readdatavalid=1, then capture avm_readdata into core_d, core_n or the c register.
  - Transitions: WT_D → RD_N; WT_N → RD_C; WT_C → SEND.
  - readdatavalid while not in a WT_x state is ignored.
- SEND:
  - core_valid=1 with core_c stable until core_ready=1, then go to COMP.
  - valid must never drop before acceptance.
- COMP:
  - core_m_ready=1. On core_m_valid=1, latch core_m into avm_writedata and go to WR_M.
- WR_M:
  - avm_write=1 and avm_address=M_BASE+32k, held until avm_waitrequest=0.
  - Then k increments.
  - If k (the old value) == NUM_BLOCKS-1 → DONE; otherwise → RD_C.
- DONE:
  - status=0x00 and k=0 on the next cycle; go to IDLE.
- Address arithmetic:
  - Computed as base + (k<<5) in ADDR_W bits. Wrap-around is not checked.
  - k is wide enough for NUM_BLOCKS.
- Mutual exclusion: avm_read and avm_write are never both 1.
- start while busy: ignored.
- start in the DONE cycle: ignored; a new start is required in IDLE.
- Key handling: d and n are fetched once per run and held on core_d and core_n until the next run.

Optional Feature:
- Macro: RSA_DMA_PERF_EN.
- When defined:
  - Adds output perf_cycles [31:0].
  - Cleared at start and incremented each cycle while status==0xFF; holds its value after DONE.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Basic run with NUM_BLOCKS=2, zero-wait memory:
  - Pulse start → reads at addresses 0, 32, 64.
  - Core send, then write to 64; read 96, write 96.
  - status returns to 0x00 within 2 cycles of the final write acceptance.
- Stalled read:
  - Hold avm_waitrequest=1 for 3 cycles on the d read → avm_read and address 0 stay constant for 4 cycles.
  - Read is issued exactly once; core_d equals the returned word.
- Slow core:
  - core_ready low for 10 cycles → core_valid stays 1 and core_c is unchanged.
  - No Avalon activity during this period.
- Stalled write:
  - Hold avm_waitrequest=1 for 5 cycles during WR_M → avm_write, avm_writedata and avm_address are stable.
  - k increments only after acceptance.
- Reset mid-run:
  - Assert reset low during WT_C of block 1 → next cycle all outputs are 0 and status=0x00.
  - A fresh start then restarts from address 0.
- start during busy:
  - Pulse start while in COMP → no extra reads.
  - Exactly NUM_BLOCKS writes are observed.
  - With RSA_DMA_PERF_EN, perf_cycles equals the measured busy cycle count.

Source files
------------

// File: rtl/rsa_mm_dma.sv
// rtl/rsa_mm_dma.sv - Avalon-MM master DMA front-end for the RSA modular-exponentiation core
//
// Purpose:
//   On a start pulse, fetches the key words d and n, then for each of NUM_BLOCKS
//   ciphertext words reads the word, hands it to the RSA core, collects the
//   plaintext result and writes it back. One memory transaction outstanding max.
//
// Ports:
//   clk, reset            - system clock, synchronous active-low reset
//   start                 - one-cycle run request (ignored unless idle)
//   status[7:0]           - 0xFF while busy, 0x00 otherwise
//   avm_*                 - Avalon-MM master (address, read, write, writedata,
//                           readdata, readdatavalid, waitrequest)
//   core_d, core_n        - registered exponent / modulus held for the whole run
//   core_c, core_valid,
//   core_ready            - ciphertext handshake to the core
//   core_m, core_m_valid,
//   core_m_ready          - result handshake from the core
//   perf_cycles[31:0]     - busy-cycle counter, only with RSA_DMA_PERF_EN defined
//
// Build option: RSA_DMA_PERF_EN adds the saturating perf_cycles counter.

module rsa_mm_dma #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 32,
   parameter int NUM_BLOCKS = 38,
   parameter int KEY_BASE   = 0,
   parameter int C_BASE     = 64,
   parameter int M_BASE     = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [7:0]        status,
   input  logic              avm_waitrequest,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [DATA_W-1:0] core_d,
   output logic [DATA_W-1:0] core_n,
   output logic [DATA_W-1:0] core_c,
   output logic              core_valid,
   input  logic              core_ready,
   input  logic [DATA_W-1:0] core_m,
   input  logic              core_m_valid,
   output logic              core_m_ready
`ifdef RSA_DMA_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   // k must be able to hold NUM_BLOCKS itself: it increments on the last write
   // before DONE clears it.
   localparam int K_W = $clog2(NUM_BLOCKS + 1);

   localparam logic [ADDR_W-1:0] D_ADDR = ADDR_W'(KEY_BASE);
   localparam logic [ADDR_W-1:0] N_ADDR = ADDR_W'(KEY_BASE + 32);
   localparam logic [ADDR_W-1:0] C_ADDR = ADDR_W'(C_BASE);
   localparam logic [ADDR_W-1:0] M_ADDR = ADDR_W'(M_BASE);
   localparam logic [K_W-1:0]    K_LAST = K_W'(NUM_BLOCKS - 1);

   typedef enum logic [3:0] {
      IDLE, RD_D, WT_D, RD_N, WT_N, RD_C, WT_C, SEND, COMP, WR_M, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [K_W-1:0]    k;
   logic [ADDR_W-1:0] k_off;

   assign k_off = ADDR_W'(k) << 5;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start)              state_nxt = RD_D;
         RD_D: if (!avm_waitrequest)   state_nxt = WT_D;
         WT_D: if (avm_readdatavalid)  state_nxt = RD_N;
         RD_N: if (!avm_waitrequest)   state_nxt = WT_N;
         WT_N: if (avm_readdatavalid)  state_nxt = RD_C;
         RD_C: if (!avm_waitrequest)   state_nxt = WT_C;
         WT_C: if (avm_readdatavalid)  state_nxt = SEND;
         SEND: if (core_ready)         state_nxt = COMP;
         COMP: if (core_m_valid)       state_nxt = WR_M;
         WR_M: if (!avm_waitrequest)   state_nxt = (k == K_LAST) ? DONE : RD_C;
         DONE:                         state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // Output logic: bus strobes and addresses depend only on state, so they
   // stay stable for as long as the slave stalls.
   always_comb begin
      avm_read     = 1'b0;
      avm_write    = 1'b0;
      avm_address  = '0;
      core_valid   = 1'b0;
      core_m_ready = 1'b0;
      status       = (state == IDLE) ? 8'h00 : 8'hFF;
      case (state)
         RD_D: begin avm_read  = 1'b1; avm_address = D_ADDR;         end
         RD_N: begin avm_read  = 1'b1; avm_address = N_ADDR;         end
         RD_C: begin avm_read  = 1'b1; avm_address = C_ADDR + k_off; end
         WR_M: begin avm_write = 1'b1; avm_address = M_ADDR + k_off; end
         SEND: core_valid   = 1'b1;
         COMP: core_m_ready = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers: key words, ciphertext, result and block index.
   // Read data outside a WT_x state falls through the case and is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         core_d        <= '0;
         core_n        <= '0;
         core_c        <= '0;
         avm_writedata <= '0;
         k             <= '0;
      end else begin
         case (state)
            WT_D: if (avm_readdatavalid) core_d        <= avm_readdata;
            WT_N: if (avm_readdatavalid) core_n        <= avm_readdata;
            WT_C: if (avm_readdatavalid) core_c        <= avm_readdata;
            COMP: if (core_m_valid)      avm_writedata <= core_m;
            WR_M: if (!avm_waitrequest)  k             <= k + 1'b1;
            DONE:                        k             <= '0;
            default: ;
         endcase
      end
   end

`ifdef RSA_DMA_PERF_EN
   // Counts every non-idle cycle of a run; cleared by the accepted start,
   // frozen while idle so software can read it after the run.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_cycles <= '0;
      end else if (state == IDLE) begin
         if (start) perf_cycles <= '0;
      end else if (perf_cycles != 32'hFFFF_FFFF) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rsa_mm_dma.sv
// tb/tb_rsa_mm_dma.sv - self-checking bench for rsa_mm_dma with memory and core models

module tb_rsa_mm_dma;

   localparam int DW = 256;
   localparam int AW = 32;
   localparam int NB = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    status;
   logic          avm_waitrequest = 1'b0;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic          avm_write;
   logic [DW-1:0] avm_writedata;
   logic [DW-1:0] avm_readdata = '0;
   logic          avm_readdatavalid = 1'b0;
   logic [DW-1:0] core_d;
   logic [DW-1:0] core_n;
   logic [DW-1:0] core_c;
   logic          core_valid;
   logic          core_ready = 1'b0;
   logic [DW-1:0] core_m = '0;
   logic          core_m_valid = 1'b0;
   logic          core_m_ready;
`ifdef RSA_DMA_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   rsa_mm_dma #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_BLOCKS(NB),
      .KEY_BASE(0), .C_BASE(64), .M_BASE(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .status(status),
      .avm_waitrequest(avm_waitrequest),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_write(avm_write),
      .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .core_d(core_d),
      .core_n(core_n),
      .core_c(core_c),
      .core_valid(core_valid),
      .core_ready(core_ready),
      .core_m(core_m),
      .core_m_valid(core_m_valid),
`ifdef RSA_DMA_PERF_EN
      .perf_cycles(perf_cycles),
`endif
      .core_m_ready(core_m_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] exp_rd_addr [$];
   logic [AW-1:0] exp_wr_addr [$];
   logic [DW-1:0] exp_wr_data [$];

   // stimulus knobs, each applies to the next matching transaction only
   int            rd_stall_next = 0;
   int            wr_stall_next = 0;
   int            rdy_stall_next = 0;
   int            m_delay = 0;
   bit            rdv_block = 0;
   logic [AW-1:0] blk_addr = '0;

   // responder state and statistics
   bit            in_req = 0;
   int            stall_left = 0;
   bit            rd_pend = 0;
   logic [AW-1:0] rd_pend_addr = '0;
   int            rd_acc = 0, wr_acc = 0, rd_hi = 0, wr_hi = 0, valid_hi = 0;
   int            wr_acc_cyc = 0, busy_cnt = 0;
   bit            c_in_req = 0;
   int            c_stall = 0;
   bit            m_pend = 0;
   int            m_wait = 0;
   logic [DW-1:0] m_val = '0;
   bit            p_rd_stall = 0, p_wr_stall = 0, p_cv_stall = 0;
   logic [AW-1:0] p_addr = '0;
   logic [DW-1:0] p_wdata = '0, p_c = '0;

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] c, d, n);
      return (c ^ d) + n;
   endfunction

   // Memory slave and RSA core models, evaluated on the falling edge
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (!reset) begin
         avm_waitrequest = 0; avm_readdatavalid = 0; core_ready = 0; core_m_valid = 0;
         in_req = 0; stall_left = 0; rd_pend = 0; c_in_req = 0; c_stall = 0;
         m_pend = 0; m_wait = 0; p_rd_stall = 0; p_wr_stall = 0; p_cv_stall = 0;
      end else begin
         if (status === 8'hFF) busy_cnt++;
         if (p_rd_stall) begin
            checks++;
            if (!(avm_read === 1'b1 && avm_write === 1'b0 && avm_address === p_addr)) begin
               failures++;
               $display("FAIL rd_hold read=%b addr=%h expected read=1 addr=%h", avm_read, avm_address, p_addr);
            end
         end
         if (p_wr_stall) begin
            checks++;
            if (!(avm_write === 1'b1 && avm_address === p_addr && avm_writedata === p_wdata)) begin
               failures++;
               $display("FAIL wr_hold write=%b addr=%h expected write=1 addr=%h data_same=%b",
                        avm_write, avm_address, p_addr, avm_writedata === p_wdata);
            end
         end
         if (p_cv_stall) begin
            checks++;
            if (!(core_valid === 1'b1 && core_c === p_c)) begin
               failures++;
               $display("FAIL core_hold valid=%b c_same=%b expected valid=1 c_same=1", core_valid, core_c === p_c);
            end
         end
         if (avm_read || avm_write) begin
            checks++;
            if (avm_read && avm_write) begin
               failures++;
               $display("FAIL mutex read=%b write=%b expected not both", avm_read, avm_write);
            end
         end
         if (core_valid) begin
            checks++;
            if (avm_read || avm_write) begin
               failures++;
               $display("FAIL bus_quiet read=%b write=%b expected 0 while core_valid", avm_read, avm_write);
            end
         end

         avm_readdatavalid = 0;
         if (rd_pend) begin
            rd_pend = 0;
            if (!(rdv_block && rd_pend_addr == blk_addr)) begin
               avm_readdatavalid = 1;
               avm_readdata = mem.exists(rd_pend_addr) ? mem[rd_pend_addr] : '0;
            end
         end

         avm_waitrequest = 0; p_rd_stall = 0; p_wr_stall = 0;
         if (avm_read || avm_write) begin
            if (!in_req) begin
               in_req = 1;
               if (avm_read) begin stall_left = rd_stall_next; rd_stall_next = 0; end
               else          begin stall_left = wr_stall_next; wr_stall_next = 0; end
            end
            if (avm_read) rd_hi++;
            if (avm_write) wr_hi++;
            if (stall_left > 0) begin
               stall_left--;
               avm_waitrequest = 1;
               p_rd_stall = avm_read; p_wr_stall = avm_write;
               p_addr = avm_address; p_wdata = avm_writedata;
            end else begin
               in_req = 0;
               checks++;
               if (avm_read) begin
                  rd_acc++; rd_pend = 1; rd_pend_addr = avm_address;
                  if (exp_rd_addr.size() == 0) begin
                     failures++;
                     $display("FAIL rd_sb got read addr=%h expected no read", avm_address);
                  end else begin
                     ea = exp_rd_addr.pop_front();
                     if (avm_address !== ea) begin
                        failures++;
                        $display("FAIL rd_sb addr=%h expected %h", avm_address, ea);
                     end
                  end
               end else begin
                  wr_acc++; wr_acc_cyc = cyc + 1;
                  if (exp_wr_addr.size() == 0) begin
                     failures++;
                     $display("FAIL wr_sb got write addr=%h expected no write", avm_address);
                  end else begin
                     ea = exp_wr_addr.pop_front();
                     ed = exp_wr_data.pop_front();
                     if (avm_address !== ea || avm_writedata !== ed) begin
                        failures++;
                        $display("FAIL wr_sb addr=%h data=%h expected addr=%h data=%h",
                                 avm_address, avm_writedata, ea, ed);
                     end
                  end
               end
            end
         end

         core_ready = 0; p_cv_stall = 0;
         if (core_valid) begin
            valid_hi++;
            if (!c_in_req) begin c_in_req = 1; c_stall = rdy_stall_next; rdy_stall_next = 0; end
            if (c_stall > 0) begin
               c_stall--; p_cv_stall = 1; p_c = core_c;
            end else begin
               c_in_req = 0; core_ready = 1;
               m_val = core_fn(core_c, core_d, core_n);
               m_pend = 1; m_wait = m_delay;
            end
         end
         core_m_valid = 0;
         if (m_pend && core_m_ready) begin
            if (m_wait > 0) m_wait--;
            else begin core_m_valid = 1; core_m = m_val; m_pend = 0; end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic setup_run();
      logic [AW-1:0] a;
      exp_rd_addr.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
      rd_acc = 0; wr_acc = 0; rd_hi = 0; wr_hi = 0; valid_hi = 0; busy_cnt = 0;
      mem.delete();
      mem[32'd0]  = rnd_word();
      mem[32'd32] = rnd_word();
      exp_rd_addr.push_back(32'd0);
      exp_rd_addr.push_back(32'd32);
      for (int i = 0; i < NB; i++) begin
         a = 32'd64 + 32'(i * 32);
         mem[a] = rnd_word();
         exp_rd_addr.push_back(a);
         exp_wr_addr.push_back(a);
         exp_wr_data.push_back(core_fn(mem[a], mem[32'd0], mem[32'd32]));
      end
   endtask

   task automatic pulse_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (status !== 8'h00 && n < 2000) begin tick(); n++; end
      checks++;
      if (status !== 8'h00) begin
         failures++;
         $display("FAIL %s_timeout status=%h expected 00", name, status);
      end
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (exp_rd_addr.size() != 0 || exp_wr_addr.size() != 0) begin
         failures++;
         $display("FAIL %s_sb_left reads=%0d writes=%0d expected 0 0", name, exp_rd_addr.size(), exp_wr_addr.size());
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (status !== 8'h00 || avm_address !== '0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
          avm_writedata !== '0 || core_d !== '0 || core_n !== '0 || core_c !== '0 ||
          core_valid !== 1'b0 || core_m_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s status=%h addr=%h rd=%b wr=%b wd0=%b d0=%b n0=%b c0=%b cv=%b mr=%b expected all 0",
                  name, status, avm_address, avm_read, avm_write, avm_writedata === '0,
                  core_d === '0, core_n === '0, core_c === '0, core_valid, core_m_ready);
      end
`ifdef RSA_DMA_PERF_EN
      check_int({name, "_perf"}, int'(perf_cycles), 0);
`endif
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) tick();
      check_outputs_zero("reset_state");
      reset = 1;
      tick();
      check_outputs_zero("post_reset_idle");
   endtask

   task automatic test_basic();
      int d;
      setup_run();
      pulse_start();
      checks++;
      if (status !== 8'hFF) begin
         failures++;
         $display("FAIL basic_busy status=%h expected ff", status);
      end
      wait_idle("basic");
      d = cyc - wr_acc_cyc;
      checks++;
      if (d < 1 || d > 2) begin
         failures++;
         $display("FAIL basic_status_lat cycles=%0d expected 1..2", d);
      end
      check_int("basic_reads", rd_acc, NB + 2);
      check_int("basic_writes", wr_acc, NB);
      check_sb_empty("basic");
      checks++;
      if (core_d !== mem[32'd0] || core_n !== mem[32'd32]) begin
         failures++;
         $display("FAIL basic_keys d=%h n=%h expected d=%h n=%h", core_d, core_n, mem[32'd0], mem[32'd32]);
      end
`ifdef RSA_DMA_PERF_EN
      check_int("basic_perf", int'(perf_cycles), busy_cnt);
`endif
   endtask

   task automatic test_stalled_read();
      setup_run();
      rd_stall_next = 3;
      pulse_start();
      wait_idle("stall_rd");
      check_int("stall_rd_hi_cycles", rd_hi, 4 + (NB + 1));
      check_int("stall_rd_reads", rd_acc, NB + 2);
      check_sb_empty("stall_rd");
      checks++;
      if (core_d !== mem[32'd0]) begin
         failures++;
         $display("FAIL stall_rd_core_d got=%h expected=%h", core_d, mem[32'd0]);
      end
   endtask

   task automatic test_slow_core();
      setup_run();
      rdy_stall_next = 10;
      pulse_start();
      wait_idle("slow_core");
      check_int("slow_core_valid_cycles", valid_hi, 11 + (NB - 1));
      check_sb_empty("slow_core");
   endtask

   task automatic test_stalled_write();
      setup_run();
      wr_stall_next = 5;
      pulse_start();
      wait_idle("stall_wr");
      check_int("stall_wr_hi_cycles", wr_hi, 6 + (NB - 1));
      check_int("stall_wr_writes", wr_acc, NB);
      check_sb_empty("stall_wr");
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      setup_run();
      rdv_block = 1;
      blk_addr = 32'd96;
      pulse_start();
      while (rd_acc < NB + 2 && n < 500) begin tick(); n++; end
      check_int("midrst_reach_wt_c", rd_acc, NB + 2);
      tick();
      checks++;
      if (avm_writedata === '0 || status !== 8'hFF) begin
         failures++;
         $display("FAIL midrst_pre status=%h wd_zero=%b expected ff and nonzero", status, avm_writedata === '0);
      end
      reset = 0;
      tick();
      check_outputs_zero("midrst_abort");
      reset = 1;
      rdv_block = 0;
      tick();
      setup_run();
      pulse_start();
      wait_idle("midrst_rerun");
      check_int("midrst_rerun_reads", rd_acc, NB + 2);
      check_int("midrst_rerun_writes", wr_acc, NB);
      check_sb_empty("midrst_rerun");
   endtask

   task automatic test_start_busy();
      int n = 0;
      setup_run();
      m_delay = 4;
      pulse_start();
      while (core_m_ready !== 1'b1 && n < 500) begin tick(); n++; end
      checks++;
      if (core_m_ready !== 1'b1) begin
         failures++;
         $display("FAIL busy_reach_comp m_ready=%b expected 1", core_m_ready);
      end
      pulse_start();
      wait_idle("start_busy");
      m_delay = 0;
      repeat (3) tick();
      check_int("busy_status_stays_idle", int'(status), 0);
      check_int("busy_reads", rd_acc, NB + 2);
      check_int("busy_writes", wr_acc, NB);
      check_sb_empty("start_busy");
`ifdef RSA_DMA_PERF_EN
      check_int("busy_perf", int'(perf_cycles), busy_cnt);
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stalled_read();
      test_slow_core();
      test_stalled_write();
      test_reset_mid_run();
      test_start_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
